// File: rtl/ext_mem_bridge.sv
// CPU-to-external-SRAM pin sequencer: ALE-muxed upper address, wait-stated WE/OE strobes; `EXT_MEM_HIADDR_CACHE_EN skips ALE/TURN on a repeated upper address.
// Latency: req->ready 3+WAIT_CYCLES (write) / 4+WAIT_CYCLES (read) with ALE, 2+WAIT_CYCLES without; no backpressure, req is only taken in IDLE.
module ext_mem_bridge #(
    parameter int ADDR_W      = 8,
    parameter int PIN_ADDR_W  = 5,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic                  ready,
    output logic                  busy,
    output logic [PIN_ADDR_W-1:0] pin_addr,
    output logic                  pin_ale,
    output logic                  pin_we,
    output logic                  pin_oe,
    output logic [7:0]            pin_data_out,
    output logic [7:0]            pin_data_oe,
    input  logic [7:0]            pin_data_in
);
    localparam int HI_W   = ADDR_W - PIN_ADDR_W;
    localparam bit HAS_HI = (HI_W > 0);

    typedef enum logic [2:0] {S_IDLE, S_ALE, S_TURN, S_ACCESS, S_DONE} state_t;

    state_t     r_state;
    logic       r_we;
    logic [7:0] r_wdata;
    logic [3:0] r_cnt;

    logic [7:0] w_hi;
    logic       w_hit;
    logic       w_skip_ale;
    logic       w_to_acc;
    logic       w_acc_we;
    logic [7:0] w_acc_wdata;

    // Upper address zero-extended to the bus width; all zeros when every bit is on pins.
    assign w_hi = 8'(addr >> PIN_ADDR_W);

`ifdef EXT_MEM_HIADDR_CACHE_EN
    logic       r_hi_valid;
    logic [7:0] r_hi_last;

    assign w_hit = r_hi_valid && (w_hi == r_hi_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi_valid <= 1'b0;
            r_hi_last  <= 8'h00;
        end else if (r_state == S_ALE) begin
            r_hi_valid <= 1'b1;
            r_hi_last  <= pin_data_out;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_skip_ale = !HAS_HI || w_hit;

    // Next cycle is an ACCESS cycle; in IDLE the request fields are not latched yet.
    assign w_to_acc = (r_state == S_IDLE && req && w_skip_ale) ||
                      (r_state == S_ALE && r_we) ||
                      (r_state == S_TURN) ||
                      (r_state == S_ACCESS && r_cnt != 4'd0);
    assign w_acc_we    = (r_state == S_IDLE) ? we : r_we;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_wdata      <= 8'h00;
            r_cnt        <= 4'd0;
            rdata        <= 8'h00;
            ready        <= 1'b0;
            busy         <= 1'b0;
            pin_addr     <= '0;
            pin_ale      <= 1'b0;
            pin_we       <= 1'b0;
            pin_oe       <= 1'b0;
            pin_data_out <= 8'h00;
            pin_data_oe  <= 8'h00;
        end else begin
            pin_ale      <= 1'b0;
            pin_we       <= 1'b0;
            pin_oe       <= 1'b0;
            pin_data_out <= 8'h00;
            pin_data_oe  <= 8'h00;
            ready        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_wdata  <= wdata;
                        pin_addr <= addr[PIN_ADDR_W-1:0];
                        busy     <= 1'b1;
                        if (w_skip_ale) begin
                            r_state <= S_ACCESS;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end else begin
                            r_state      <= S_ALE;
                            pin_ale      <= 1'b1;
                            pin_data_oe  <= 8'hFF;
                            pin_data_out <= w_hi;
                        end
                    end
                end
                S_ALE: begin
                    if (r_we) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 4'(WAIT_CYCLES);
                    end else begin
                        r_state <= S_TURN;
                    end
                end
                S_TURN: begin
                    r_state <= S_ACCESS;
                    r_cnt   <= 4'(WAIT_CYCLES);
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        ready   <= 1'b1;
                        if (!r_we) begin
                            rdata <= pin_data_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_to_acc) begin
                pin_we       <= w_acc_we;
                pin_oe       <= !w_acc_we;
                pin_data_oe  <= {8{w_acc_we}};
                pin_data_out <= w_acc_we ? w_acc_wdata : 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_ext_mem_bridge.sv
// Bench for ext_mem_bridge: three parameterisations, each attached to an external '373 latch + SRAM model,
// checked cycle by cycle against a phase-sequence reference derived from the access rules.
`timescale 1ns/1ps
module tb_ext_mem_bridge;
    localparam int ND  = 3;
    localparam int AW0 = 8,  PW0 = 5, WC0 = 1;
    localparam int AW1 = 5,  PW1 = 5, WC1 = 0;
    localparam int AW2 = 12, PW2 = 6, WC2 = 2;
    localparam int PH_ALE = 0, PH_TURN = 1, PH_ACC = 2, PH_DONE = 3;
`ifdef EXT_MEM_HIADDR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        t_req [ND];
    logic        t_we [ND];
    logic [7:0]  t_wdata [ND];
    logic [7:0]  a0;
    logic [4:0]  a1;
    logic [11:0] a2;
    logic [4:0]  pa0;
    logic [4:0]  pa1;
    logic [5:0]  pa2;
    logic [7:0]  d_paddr [ND];
    logic [7:0]  d_rdata [ND];
    logic [7:0]  d_dout [ND];
    logic [7:0]  d_doe [ND];
    logic [7:0]  d_din [ND];
    logic        d_ready [ND];
    logic        d_busy [ND];
    logic        d_ale [ND];
    logic        d_pwe [ND];
    logic        d_poe [ND];

    ext_mem_bridge #(.ADDR_W(AW0), .PIN_ADDR_W(PW0), .WAIT_CYCLES(WC0)) u_dut0 (
        .clk(clk), .reset(reset), .req(t_req[0]), .we(t_we[0]), .addr(a0), .wdata(t_wdata[0]),
        .rdata(d_rdata[0]), .ready(d_ready[0]), .busy(d_busy[0]), .pin_addr(pa0), .pin_ale(d_ale[0]),
        .pin_we(d_pwe[0]), .pin_oe(d_poe[0]), .pin_data_out(d_dout[0]), .pin_data_oe(d_doe[0]),
        .pin_data_in(d_din[0]));
    ext_mem_bridge #(.ADDR_W(AW1), .PIN_ADDR_W(PW1), .WAIT_CYCLES(WC1)) u_dut1 (
        .clk(clk), .reset(reset), .req(t_req[1]), .we(t_we[1]), .addr(a1), .wdata(t_wdata[1]),
        .rdata(d_rdata[1]), .ready(d_ready[1]), .busy(d_busy[1]), .pin_addr(pa1), .pin_ale(d_ale[1]),
        .pin_we(d_pwe[1]), .pin_oe(d_poe[1]), .pin_data_out(d_dout[1]), .pin_data_oe(d_doe[1]),
        .pin_data_in(d_din[1]));
    ext_mem_bridge #(.ADDR_W(AW2), .PIN_ADDR_W(PW2), .WAIT_CYCLES(WC2)) u_dut2 (
        .clk(clk), .reset(reset), .req(t_req[2]), .we(t_we[2]), .addr(a2), .wdata(t_wdata[2]),
        .rdata(d_rdata[2]), .ready(d_ready[2]), .busy(d_busy[2]), .pin_addr(pa2), .pin_ale(d_ale[2]),
        .pin_we(d_pwe[2]), .pin_oe(d_poe[2]), .pin_data_out(d_dout[2]), .pin_data_oe(d_doe[2]),
        .pin_data_in(d_din[2]));

    function automatic int p_aw(int s);
        case (s) 0: return AW0; 1: return AW1; default: return AW2; endcase
    endfunction
    function automatic int p_pw(int s);
        case (s) 0: return PW0; 1: return PW1; default: return PW2; endcase
    endfunction
    function automatic int p_wc(int s);
        case (s) 0: return WC0; 1: return WC1; default: return WC2; endcase
    endfunction
    function automatic logic [7:0] dflt(int s, int a);
        return 8'(a * 37 + s * 11 + 5);
    endfunction

    // External world: address latch transparent on ALE, SRAM written on WE, driven on OE.
    logic [7:0] lat [ND];
    bit   [7:0] ram [ND][4096];
    bit         ram_v [ND][4096];

    function automatic int ram_idx(int s);
        int hi;
        hi = (p_aw(s) > p_pw(s)) ? int'(lat[s]) : 0;
        return ((hi << p_pw(s)) | int'(d_paddr[s])) & 4095;
    endfunction

    always_comb begin
        d_paddr[0] = {3'b000, pa0};
        d_paddr[1] = {3'b000, pa1};
        d_paddr[2] = {2'b00, pa2};
    end

    always_comb begin
        for (int s = 0; s < ND; s++) begin
            d_din[s] = 8'hEE;
            if (d_poe[s]) begin
                d_din[s] = ram_v[s][ram_idx(s)] ? ram[s][ram_idx(s)] : dflt(s, ram_idx(s));
            end
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < ND; s++) begin
            if (d_ale[s]) lat[s] <= d_dout[s];
            if (d_pwe[s]) begin
                ram[s][ram_idx(s)]   <= d_dout[s];
                ram_v[s][ram_idx(s)] <= 1'b1;
            end
        end
    end

    // Reference state: what the CPU should see, independent of the pin sequencing.
    bit   [7:0] refm [ND][4096];
    bit         ref_v [ND][4096];
    bit         hi_valid [ND];
    int         hi_last [ND];
    logic [7:0] last_rd [ND];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [28:0] mk(logic ale, logic w, logic o, logic [7:0] doe, logic [7:0] dout,
                                       logic rdy, logic bsy, logic [7:0] pa);
        return {ale, w, o, doe, (doe != 8'h00) ? dout : 8'h00, rdy, bsy, pa};
    endfunction

    function automatic logic [28:0] obs_vec(int s);
        return mk(d_ale[s], d_pwe[s], d_poe[s], d_doe[s], d_dout[s], d_ready[s], d_busy[s], d_paddr[s]);
    endfunction

    function automatic logic [28:0] exp_vec(int ph, bit w, logic [7:0] hi, logic [7:0] wd, logic [7:0] pa);
        case (ph)
            PH_ALE:  return mk(1'b1, 1'b0, 1'b0, 8'hFF, hi, 1'b0, 1'b1, pa);
            PH_TURN: return mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, pa);
            PH_ACC:  return w ? mk(1'b0, 1'b1, 1'b0, 8'hFF, wd, 1'b0, 1'b1, pa)
                              : mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, pa);
            default: return mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, pa);
        endcase
    endfunction

    function automatic logic [36:0] zero_vec(int s);
        return {d_ale[s], d_pwe[s], d_poe[s], d_doe[s], d_dout[s], d_ready[s], d_busy[s], d_paddr[s], d_rdata[s]};
    endfunction

    task automatic drive(int s, bit rq, bit w, int a, logic [7:0] wd);
        t_req[s]   = rq;
        t_we[s]    = w;
        t_wdata[s] = wd;
        case (s)
            0:       a0 = 8'(a);
            1:       a1 = 5'(a);
            default: a2 = 12'(a);
        endcase
    endtask

    // Issue one request at the current negedge (DUT idle) and follow it to the IDLE cycle after DONE.
    task automatic do_txn(int s, bit w, int addr, logic [7:0] wd, bit hold, bit abort2);
        int aw, pw, a, hi, acc_seen;
        logic [7:0] pa, exp_rd;
        logic [28:0] ev, ov;
        logic [5:0] idle_o;
        bit hit;
        int ph[$];
        aw = p_aw(s); pw = p_pw(s);
        a  = addr & ((1 << aw) - 1);
        hi = a >> pw;
        pa = 8'(a & ((1 << pw) - 1));
        hit = CACHE_EN && (aw > pw) && hi_valid[s] && (hi == hi_last[s]);
        if (aw > pw && !hit) begin
            ph.push_back(PH_ALE);
            if (!w) ph.push_back(PH_TURN);
            hi_valid[s] = 1'b1;
            hi_last[s]  = hi;
        end
        for (int k = 0; k <= p_wc(s); k++) ph.push_back(PH_ACC);
        ph.push_back(PH_DONE);
        exp_rd = ref_v[s][a] ? refm[s][a] : dflt(s, a);
        if (w) begin
            refm[s][a]  = wd;
            ref_v[s][a] = 1'b1;
        end

        drive(s, 1'b1, w, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive(s, hold, 1'($urandom), int'($urandom), 8'($urandom));
        acc_seen = 0;
        foreach (ph[k]) begin
            ev = exp_vec(ph[k], w, 8'(hi), wd, pa);
            ov = obs_vec(s);
            n_checks++;
            if (ov !== ev) $display("FAIL phase%0d dut%0d addr=%h we=%0d: got %h want %h", k, s, a, w, ov, ev);
            else n_pass++;
            if (ph[k] == PH_DONE && !w) begin
                n_checks++;
                if (d_rdata[s] !== exp_rd) $display("FAIL rdata dut%0d addr=%h: got %h want %h", s, a, d_rdata[s], exp_rd);
                else n_pass++;
                last_rd[s] = exp_rd;
            end
            if (ph[k] == PH_ACC) acc_seen++;
            if (abort2 && ph[k] == PH_ACC && acc_seen == 2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                for (int d = 0; d < ND; d++) begin
                    hi_valid[d] = 1'b0;
                    last_rd[d]  = 8'h00;
                end
                n_checks++;
                if (zero_vec(s) !== 37'd0) $display("FAIL abort_state dut%0d: got %h want 0", s, zero_vec(s));
                else n_pass++;
                @(negedge clk);
                n_checks++;
                if ({d_ready[s], d_busy[s]} !== 2'b00) $display("FAIL abort_ready dut%0d: got %b want 00", s, {d_ready[s], d_busy[s]});
                else n_pass++;
                return;
            end
            @(negedge clk);
        end
        idle_o = {d_ale[s], d_pwe[s], d_poe[s], (d_doe[s] != 8'h00), d_ready[s], d_busy[s]};
        n_checks++;
        if (idle_o !== 6'd0 || d_rdata[s] !== last_rd[s])
            $display("FAIL idle dut%0d: got flags %b rdata %h want 000000 rdata %h", s, idle_o, d_rdata[s], last_rd[s]);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int s = 0; s < ND; s++) drive(s, 1'b0, 1'b0, 0, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < ND; s++) begin
            n_checks++;
            if (zero_vec(s) !== 37'd0) $display("FAIL reset dut%0d: got %h want 0", s, zero_vec(s));
            else n_pass++;
        end
    endtask

    task automatic test_write_defaults();
        do_txn(0, 1'b1, 'h41, 8'h3C, 1'b0, 1'b0);
        do_txn(0, 1'b1, 'hE3, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_read_defaults();
        do_txn(0, 1'b0, 'h41, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_no_hi();
        do_txn(1, 1'b1, 'h1F, 8'h99, 1'b0, 1'b0);
        do_txn(1, 1'b0, 'h1F, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        do_txn(0, 1'b1, 'hC6, 8'h5D, 1'b0, 1'b1);
        do_txn(0, 1'b0, 'h8B, 8'h00, 1'b0, 1'b0);
        do_txn(0, 1'b0, 'hC6, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_hiaddr_cache();
        do_txn(0, 1'b0, 'hE0, 8'h00, 1'b0, 1'b0);
        do_txn(0, 1'b0, 'hE1, 8'h00, 1'b0, 1'b0);
        do_txn(0, 1'b0, 'h20, 8'h00, 1'b0, 1'b0);
        do_txn(2, 1'b0, 'hABC, 8'h00, 1'b0, 1'b0);
        do_txn(2, 1'b1, 'hA80, 8'h6E, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn(0, 1'b1, 'h15, 8'h11, 1'b1, 1'b0);
        do_txn(0, 1'b1, 'h75, 8'h22, 1'b1, 1'b0);
        do_txn(0, 1'b1, 'hD5, 8'h33, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 0, 8'h00);
        do_txn(0, 1'b0, 'h15, 8'h00, 1'b0, 1'b0);
        do_txn(0, 1'b0, 'h75, 8'h00, 1'b0, 1'b0);
        do_txn(0, 1'b0, 'hD5, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 150; n++) begin
            s = $urandom_range(0, ND - 1);
            // Small address pool per device so reads often hit earlier writes.
            do_txn(s, 1'($urandom), int'($urandom_range(0, 4095)) & (((n % 3) == 0) ? 4095 : 'h3F7),
                   8'($urandom), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < ND; s++) begin
            hi_valid[s] = 1'b0;
            hi_last[s]  = 0;
            last_rd[s]  = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_write_defaults();
        test_read_defaults();
        test_no_hi();
        test_reset_abort();
        test_hiaddr_cache();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
